kd_tree_ctrl: RTL and testbench

KD_TREE_CTRL -- requirements
Module: kd_tree_ctrl

---
 rtl/kd_pkg.sv | 13 +
 rtl/kd_res_fifo.sv | 60 ++++++
 rtl/kd_tree_ctrl.sv | 122 ++++++++++++
 tb/tb_kd_tree_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// Shared definitions for the kd-tree controller: default widths and FSM encoding.
package kd_pkg;

  localparam int unsigned KD_DATA_WIDTH    = 55;
  localparam int unsigned KD_STORAGE_WIDTH = 22;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } kd_state_e;

endpackage

// File: rtl/kd_res_fifo.sv
// Result FIFO for traversal leaf indices; drops pushes when full and latches a sticky error.
module kd_res_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !do_push) err <= 1'b1;
    end
  end

endmodule

// File: rtl/kd_tree_ctrl.sv
// kd-tree controller: loads node config words, issues queries with credit flow control,
// and returns leaf results in order through a FIFO.
module kd_tree_ctrl
  import kd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = KD_DATA_WIDTH,
  parameter int unsigned STORAGE_WIDTH = KD_STORAGE_WIDTH,
  parameter int unsigned NUM_NODES     = 7,
  parameter int unsigned LEAF_W        = 3,
  parameter int unsigned RES_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [STORAGE_WIDTH-1:0] cfg_wdata,
  output logic [NUM_NODES-1:0]     node_wen,
  output logic [STORAGE_WIDTH-1:0] node_wdata,
  input  logic                     q_valid,
  output logic                     q_ready,
  input  logic [DATA_WIDTH-1:0]    q_patch,
  output logic                     pipe_valid,
  output logic [DATA_WIDTH-1:0]    pipe_patch,
  input  logic                     leaf_valid,
  input  logic [LEAF_W-1:0]        leaf_idx,
  output logic                     res_valid,
  output logic [LEAF_W-1:0]        res_idx,
  input  logic                     res_ready,
  input  logic                     clear,
  output logic                     loaded,
  output logic                     err
);

  localparam int unsigned CNT_W  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int unsigned CRED_W = $clog2(RES_DEPTH + 1);

  kd_state_e         state;
  logic [CNT_W-1:0]  node_cnt;
  logic [CNT_W-1:0]  wr_idx;
  logic [CRED_W-1:0] credits;
  logic              cfg_hs;
  logic              q_hs;
  logic              res_hs;
  logic              fifo_empty;
  logic              unused_fifo_full;

  // Handshake readiness depends only on registered state and clear, never on leaf_valid.
  assign cfg_ready = (state == ST_LOAD);
  assign q_ready   = (state == ST_RUN) && (credits < CRED_W'(RES_DEPTH)) && !clear;
  assign res_valid = !fifo_empty;
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign q_hs      = q_valid && q_ready;
  assign res_hs    = res_valid && res_ready;
  // A clear during load restarts numbering, so a same-cycle word lands on node 0.
  assign wr_idx    = clear ? '0 : node_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_LOAD;
      node_cnt   <= '0;
      credits    <= '0;
      node_wen   <= '0;
      node_wdata <= '0;
      pipe_valid <= 1'b0;
      pipe_patch <= '0;
      loaded     <= 1'b0;
    end else begin
      node_wen   <= '0;
      pipe_valid <= q_hs;
      if (q_hs) pipe_patch <= q_patch;

      if (q_hs && !res_hs)
        credits <= credits + CRED_W'(1);
      else if (!q_hs && res_hs && (credits != '0))
        credits <= credits - CRED_W'(1);

      case (state)
        ST_LOAD: begin
          if (cfg_hs) begin
            node_wen   <= NUM_NODES'(1) << wr_idx;
            node_wdata <= cfg_wdata;
            if (wr_idx == CNT_W'(NUM_NODES - 1)) begin
              state    <= ST_RUN;
              loaded   <= 1'b1;
              node_cnt <= '0;
            end else begin
              node_cnt <= wr_idx + CNT_W'(1);
            end
          end else if (clear) begin
            node_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (clear) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (credits == '0) begin
            state  <= ST_LOAD;
            loaded <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  kd_res_fifo #(
    .WIDTH (LEAF_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (leaf_valid),
    .push_data (leaf_idx),
    .pop       (res_ready),
    .head      (res_idx),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .err       (err)
  );

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Directed bench for kd_tree_ctrl: load, query ordering, backpressure, reload, overflow, reset.
module tb_kd_tree_ctrl;

  localparam int unsigned DW = 55;
  localparam int unsigned SW = 22;
  localparam int unsigned NN = 7;
  localparam int unsigned LW = 3;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [SW-1:0] cfg_wdata = '0;
  logic [NN-1:0] node_wen;
  logic [SW-1:0] node_wdata;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [DW-1:0] q_patch = '0;
  logic          pipe_valid;
  logic [DW-1:0] pipe_patch;
  logic          leaf_valid = 1'b0;
  logic [LW-1:0] leaf_idx = '0;
  logic          res_valid;
  logic [LW-1:0] res_idx;
  logic          res_ready = 1'b0;
  logic          clear = 1'b0;
  logic          loaded;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kd_tree_ctrl #(
    .DATA_WIDTH    (DW),
    .STORAGE_WIDTH (SW),
    .NUM_NODES     (NN),
    .LEAF_W        (LW),
    .RES_DEPTH     (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_wdata  (cfg_wdata),
    .node_wen   (node_wen),
    .node_wdata (node_wdata),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_patch    (q_patch),
    .pipe_valid (pipe_valid),
    .pipe_patch (pipe_patch),
    .leaf_valid (leaf_valid),
    .leaf_idx   (leaf_idx),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_ready  (res_ready),
    .clear      (clear),
    .loaded     (loaded),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_query(input logic [DW-1:0] p);
    q_valid = 1'b1;
    q_patch = p;
    settle();
    chk("q_ready_run", 64'(q_ready), 64'd1);
    tick();
    q_valid = 1'b0;
    chk("pipe_valid", 64'(pipe_valid), 64'd1);
    chk("pipe_patch", 64'(pipe_patch), 64'(p));
  endtask

  task automatic push_leaf(input logic [LW-1:0] idx);
    leaf_valid = 1'b1;
    leaf_idx   = idx;
    tick();
    leaf_valid = 1'b0;
  endtask

  task automatic pop_exp(input logic [LW-1:0] idx);
    res_ready = 1'b1;
    settle();
    chk("res_valid_pop", 64'(res_valid), 64'd1);
    chk("res_idx", 64'(res_idx), 64'(idx));
    tick();
    res_ready = 1'b0;
  endtask

  task automatic load_word(input int k, input logic [SW-1:0] w);
    logic [NN-1:0] exp_wen;
    exp_wen   = NN'(1) << k;
    cfg_valid = 1'b1;
    cfg_wdata = w;
    settle();
    chk("cfg_ready_load", 64'(cfg_ready), 64'd1);
    tick();
    chk("node_wen", 64'(node_wen), 64'(exp_wen));
    chk("node_wdata", 64'(node_wdata), 64'(w));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pa;
    bit            got_unload;

    // Reset values, including the combinational handshake outputs.
    settle();
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_q_ready", 64'(q_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_node_wen", 64'(node_wen), 64'd0);
    chk("rst_node_wdata", 64'(node_wdata), 64'd0);
    chk("rst_pipe_valid", 64'(pipe_valid), 64'd0);
    chk("rst_pipe_patch", 64'(pipe_patch), 64'd0);
    chk("rst_loaded", 64'(loaded), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    rst_n = 1'b0;
    tick();

    // Full tree load.
    for (int k = 0; k < NN; k++) begin
      if (k == 0) chk("q_ready_in_load", 64'(q_ready), 64'd0);
      load_word(k, SW'(22'h000401 + k));
    end
    cfg_valid = 1'b0;
    settle();
    chk("loaded_after_load", 64'(loaded), 64'd1);
    chk("q_ready_after_load", 64'(q_ready), 64'd1);
    chk("cfg_ready_run", 64'(cfg_ready), 64'd0);
    tick();
    chk("node_wen_idle", 64'(node_wen), 64'd0);

    // Ordering and simultaneous push/pop.
    pa = 55'h0123_4567_89AB;
    do_query(pa);
    push_leaf(3'd5);
    chk("pipe_valid_idle", 64'(pipe_valid), 64'd0);
    chk("pipe_patch_hold", 64'(pipe_patch), 64'(pa));
    do_query(55'h7F_0000_0000_0001);
    do_query(55'h00_AAAA_5555_AAAA);
    push_leaf(3'd2);
    push_leaf(3'd7);
    q_valid    = 1'b1;
    q_patch    = 55'h15;
    leaf_valid = 1'b1;
    leaf_idx   = 3'd3;
    res_ready  = 1'b1;
    settle();
    chk("sim_res_idx", 64'(res_idx), 64'd5);
    chk("sim_q_ready", 64'(q_ready), 64'd1);
    tick();
    q_valid    = 1'b0;
    leaf_valid = 1'b0;
    res_ready  = 1'b0;
    pop_exp(3'd2);
    pop_exp(3'd7);
    pop_exp(3'd3);
    settle();
    chk("order_empty", 64'(res_valid), 64'd0);

    // Backpressure: four outstanding credits block the fifth query.
    for (int i = 0; i < RD; i++) begin
      do_query(DW'(i + 10));
      push_leaf(LW'(i));
    end
    q_valid = 1'b1;
    q_patch = 55'h99;
    settle();
    chk("q_ready_credit_full", 64'(q_ready), 64'd0);
    tick();
    chk("pipe_valid_blocked", 64'(pipe_valid), 64'd0);
    q_valid = 1'b0;
    pop_exp(3'd0);
    settle();
    chk("q_ready_after_pop", 64'(q_ready), 64'd1);

    // Reload with two results outstanding.
    pop_exp(3'd1);
    clear = 1'b1;
    settle();
    chk("q_ready_clear", 64'(q_ready), 64'd0);
    tick();
    settle();
    chk("drain_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("drain_q_ready", 64'(q_ready), 64'd0);
    chk("drain_loaded", 64'(loaded), 64'd1);
    pop_exp(3'd2);
    clear = 1'b0;
    pop_exp(3'd3);
    got_unload = 1'b0;
    for (int c = 0; c < 8 && !got_unload; c++) begin
      if (loaded == 1'b0) got_unload = 1'b1;
      else tick();
    end
    chk("reload_loaded", 64'(loaded), 64'd0);
    chk("reload_cfg_ready", 64'(cfg_ready), 64'd1);

    // clear during load restarts numbering at node 0.
    load_word(0, 22'h000500);
    load_word(1, 22'h000501);
    cfg_valid = 1'b1;
    cfg_wdata = 22'h0005AA;
    clear     = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_load_node0", 64'(node_wen), 64'd1);
    chk("clear_load_wdata", 64'(node_wdata), 64'h5AA);
    for (int k = 1; k < NN; k++) load_word(k, SW'(22'h000600 + k));
    cfg_valid = 1'b0;
    settle();
    chk("reload_done", 64'(loaded), 64'd1);

    // Overflow: five unsolicited results into a depth-four FIFO.
    for (int i = 1; i <= 5; i++) begin
      push_leaf(LW'(i));
      if (i == 4) chk("err_before_ovf", 64'(err), 64'd0);
    end
    chk("err_after_ovf", 64'(err), 64'd1);
    for (int i = 1; i <= 4; i++) pop_exp(LW'(i));
    settle();
    chk("ovf_count4_empty", 64'(res_valid), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("pop_empty_ignored", 64'(res_valid), 64'd0);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset clears sticky state and aborts a partial load.
    rst_n = 1'b1;
    settle();
    chk("rst2_err", 64'(err), 64'd0);
    chk("rst2_loaded", 64'(loaded), 64'd0);
    chk("rst2_cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) load_word(k, SW'(22'h000700 + k));
    cfg_valid = 1'b0;
    rst_n     = 1'b1;
    settle();
    chk("rst_mid_wen", 64'(node_wen), 64'd0);
    tick();
    chk("rst_hold_wen", 64'(node_wen), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("post_rst_wen", 64'(node_wen), 64'd0);
    load_word(0, 22'h0003FF);
    cfg_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
